fifo_param: RTL

Parametrised synchronous FIFO and the next generation of the team's 8-bit FIFO. It adds configurable data width and depth, an occupancy count, full/empty and programmable almost-full/almost-empty flags, and a synchronous flush. It keeps the active-low write/read strobes and the over_flow/under_flow error reporting used by the existing bench interfaces, so current UVM agents attach with only width changes.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_mem.sv | 43 ++++
 rtl/fifo_param.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and width helpers for the parametrised FIFO.
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 16;

  // Occupancy needs to represent 0..DEPTH inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTHxDATA_W storage, one write port and one registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int  DATA_W = FIFO_DATA_W,
  parameter int  DEPTH  = FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Storage array is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register: reads the pre-write word when raddr == waddr on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (clr) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/fifo_param.sv
// fifo_param: synchronous FIFO with occupancy count, almost flags, flush and error flags.
// Build option FIFO_ERR_STICKY_EN: over_flow/under_flow latch until rst_n or clr.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int  DATA_W   = FIFO_DATA_W,
  parameter int  DEPTH    = FIFO_DEPTH,
  parameter int  AF_LEVEL = DEPTH - 2,
  parameter int  AE_LEVEL = 2,
  localparam int CNT_W    = fifo_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_n,
  input  logic              rd_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              over_flow,
  output logic              under_flow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             full_s;
  logic             empty_s;
  logic             wr_ok_s;
  logic             rd_ok_s;
  logic             ovf_s;
  logic             unf_s;
  logic             over_r;
  logic             under_r;

  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign empty_s = (count_r == {CNT_W{1'b0}});

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_ok_s = !rd_n && !empty_s;
  assign wr_ok_s = !wr_n && (!full_s || rd_ok_s);
  assign ovf_s   = !wr_n && full_s && !rd_ok_s;
  assign unf_s   = !rd_n && empty_s;

  // Next occupancy from the accepted write/read pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (wr_ok_s) begin
        wptr_r <= wptr_r + PTR_W'(1);
      end
      if (rd_ok_s) begin
        rptr_r <= rptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Error flags: registered one edge after the offending strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      over_r  <= 1'b0;
      under_r <= 1'b0;
    end else if (clr) begin
      over_r  <= 1'b0;
      under_r <= 1'b0;
    end else begin
`ifdef FIFO_ERR_STICKY_EN
      over_r  <= over_r | ovf_s;
      under_r <= under_r | unf_s;
`else
      over_r  <= ovf_s;
      under_r <= unf_s;
`endif
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .we    (wr_ok_s && !clr),
    .waddr (wptr_r),
    .wdata (din),
    .re    (rd_ok_s && !clr),
    .raddr (rptr_r),
    .rdata (dout)
  );

  assign count        = count_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_r >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_r <= CNT_W'(AE_LEVEL));
  assign over_flow    = over_r;
  assign under_flow   = under_r;

endmodule
